// File: rtl/gaussian_pass_scheduler.sv
// gaussian_pass_scheduler: frame-granular round-robin sharing of one Gaussian blur filter + output FIFO
module gaussian_pass_scheduler #(
  parameter int WIDTH = 400,
  parameter int HEIGHT = 300,
  parameter int PRIME = 806,
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   src_valid,
  input  logic [8*NREQ-1:0] src_data,
  output logic [NREQ-1:0]   src_rd_en,
  output logic [NREQ-1:0]   gnt,
  output logic              g_en,
  output logic [7:0]        g_din,
  output logic              g_clr,
  input  logic              sink_full,
  output logic              sink_wr_en,
  output logic              frame_done,
  output logic              busy
);
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int PW = $clog2(TOTAL + PRIME + 1);
  localparam int OW = $clog2(TOTAL + 1);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [2:0] {IDLE, GRANT, STREAM, FLUSH, DONE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] push_cnt;
  logic [OW-1:0] out_cnt;
  logic [IW-1:0] rr_ptr, gidx, sel;
  logic push, fpush;
  // first set request bit at or after the round-robin pointer, wrapping
  function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] s;
    int j;
    s = p;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(p) + k;
      j = j >= NREQ ? j - NREQ : j;
      if (r[j]) s = IW'(j);
    end
    return s;
  endfunction
  assign sel = pick(req, rr_ptr);
  assign push = state == STREAM && src_valid[gidx] && !sink_full;
  assign fpush = state == FLUSH && !sink_full;
  assign g_en = push || fpush;
  assign src_rd_en = push ? NREQ'(1) << gidx : '0;
  assign g_din = push ? src_data[gidx*8 +: 8] : 8'd0;
  assign sink_wr_en = fpush || (push && push_cnt >= PW'(PRIME));
  assign g_clr = state == GRANT;
  assign frame_done = state == DONE;
  assign busy = state != IDLE;
  // next state: whole frame per grant, flush ends when the last output is written
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = |req ? GRANT : IDLE;
      GRANT:   state_nx = STREAM;
      STREAM:  state_nx = push && push_cnt == PW'(TOTAL - 1) ? FLUSH : STREAM;
      FLUSH:   state_nx = fpush && out_cnt == OW'(TOTAL - 1) ? DONE : FLUSH;
      default: state_nx = IDLE;
    endcase
  end
  // state, grant, round-robin pointer and push/output counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      gidx <= '0;
      rr_ptr <= '0;
      push_cnt <= '0;
      out_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && |req) begin
        gidx <= sel;
        gnt <= NREQ'(1) << sel;
      end
      if (state == GRANT) begin
        push_cnt <= '0;
        out_cnt <= '0;
      end
      if (g_en) push_cnt <= push_cnt + PW'(1);
      if (sink_wr_en) out_cnt <= out_cnt + OW'(1);
      if (state == DONE) begin
        gnt <= '0;
        rr_ptr <= gidx == IW'(NREQ - 1) ? '0 : gidx + IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_gaussian_pass_scheduler.sv
// tb_gaussian_pass_scheduler: table vectors, corner sequences and random stimulus against a frame-timeline model
module tb_gaussian_pass_scheduler;
  localparam int W = 8, H = 4, PR = 18, N = 2, TOT = W * H;
  logic clk = 0, rst_n = 0, sink_full = 0;
  logic [N-1:0] req = '0, src_valid = '0;
  logic [8*N-1:0] src_data = '0;
  logic [N-1:0] src_rd_en, gnt;
  logic g_en, g_clr, sink_wr_en, frame_done, busy;
  logic [7:0] g_din;
  logic [8:0] obs;
  gaussian_pass_scheduler #(.WIDTH(W), .HEIGHT(H), .PRIME(PR), .NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .src_valid(src_valid), .src_data(src_data),
    .src_rd_en(src_rd_en), .gnt(gnt), .g_en(g_en), .g_din(g_din), .g_clr(g_clr),
    .sink_full(sink_full), .sink_wr_en(sink_wr_en), .frame_done(frame_done), .busy(busy)
  );
  always #5 clk = ~clk;
  assign obs = {gnt, src_rd_en, busy, g_en, g_clr, sink_wr_en, frame_done};
  int checks = 0, failures = 0;
  // model: k is the position in the frame timeline (-2 idle, -1 clear, 0..TOT+PR-1 pushes, TOT+PR done)
  int k = -2, g = 0, rr = 0, cyc_n = 0, wr_n = 0, pop_n = 0, n_done = 0;
  int last_cyc = 0, last_wr = 0, last_pop = 0;
  logic [N-1:0] last_gnt = '0;
  typedef struct {logic [N-1:0] req; logic [N-1:0] gnt; int writes; int cycles;} vec_t;
  vec_t tab[7];
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [8:0] pack(logic [N-1:0] gn, logic [N-1:0] rd, logic b, logic e, logic c, logic w, logic d);
    return {gn, rd, b, e, c, w, d};
  endfunction
  function automatic int pick(logic [N-1:0] r, int p);
    for (int o = 0; o < N; o++) if (r[(p + o) % N]) return (p + o) % N;
    return p;
  endfunction
  task automatic model_step();
    logic [N-1:0] oh;
    logic can, src;
    oh = N'(1) << g;
    if (!rst_n) begin
      check("reset_outputs", {obs, g_din}, 0);
      k = -2;
      rr = 0;
    end else if (k == -2) begin
      check("idle", obs, 0);
      if (|req) begin
        g = pick(req, rr);
        k = -1;
      end
    end else if (k == -1) begin
      check("grant_clr", obs, pack(oh, '0, 1, 0, 1, 0, 0));
      last_gnt = gnt;
      cyc_n = 1;
      wr_n = 0;
      pop_n = 0;
      k = 0;
    end else if (k < TOT + PR) begin
      cyc_n++;
      src = k < TOT;
      can = !sink_full && (src ? src_valid[g] : 1'b1);
      check("push", obs, pack(oh, (can && src) ? oh : '0, 1, can, 0, can && k >= PR, 0));
      if (can) check("g_din", g_din, src ? src_data[8*g +: 8] : 8'd0);
      wr_n += int'(sink_wr_en);
      pop_n += int'(|src_rd_en);
      if (can) k++;
    end else begin
      cyc_n++;
      check("done", obs, pack(oh, '0, 1, 0, 0, 0, 1));
      last_cyc = cyc_n;
      last_wr = wr_n;
      last_pop = pop_n;
      n_done++;
      rr = (g + 1) % N;
      k = -2;
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    src_data = 16'($urandom);
  endtask
  task automatic wait_done(string name);
    int d0, n;
    d0 = n_done;
    n = 0;
    while (n_done == d0 && n < 400) begin
      cyc();
      n++;
    end
    check({name, "_frame_timeout"}, n_done != d0, 1);
  endtask
  task automatic wait_k(int t);
    int n;
    n = 0;
    while (k < t && n < 200) begin
      cyc();
      n++;
    end
    check("wait_push_timeout", k >= t, 1);
  endtask
  initial begin
    int d0, n;
    tab[0] = '{2'b01, 2'b01, 32, 52};
    tab[1] = '{2'b11, 2'b10, 32, 52};
    tab[2] = '{2'b11, 2'b01, 32, 52};
    tab[3] = '{2'b01, 2'b01, 32, 52};
    tab[4] = '{2'b10, 2'b10, 32, 52};
    tab[5] = '{2'b10, 2'b10, 32, 52};
    tab[6] = '{2'b11, 2'b01, 32, 52};
    repeat (3) cyc();
    rst_n = 1;
    src_valid = 2'b11;
    for (int i = 0; i < 7; i++) begin
      req = tab[i].req;
      wait_done("table");
      check("table_gnt", last_gnt, tab[i].gnt);
      check("table_writes", last_wr, tab[i].writes);
      check("table_cycles", last_cyc, tab[i].cycles);
    end
    req = 2'b01;
    wait_k(10);
    sink_full = 1;
    repeat (5) cyc();
    sink_full = 0;
    wait_k(40);
    sink_full = 1;
    repeat (3) cyc();
    sink_full = 0;
    wait_done("backpressure");
    req = 0;
    check("bp_writes", last_wr, 32);
    check("bp_cycles", last_cyc, 60);
    req = 2'b01;
    d0 = n_done;
    n = 0;
    while (n_done == d0 && n < 400) begin
      cyc();
      n++;
      src_valid = n[0] ? 2'b00 : 2'b11;
    end
    check("starve_frame_timeout", n_done != d0, 1);
    req = 0;
    src_valid = 2'b11;
    check("starve_writes", last_wr, 32);
    check("starve_pops", last_pop, 32);
    req = 2'b01;
    wait_k(10);
    rst_n = 0;
    #1;
    check("rst_same_cycle", {obs, g_din}, 0);
    req = 2'b10;
    cyc();
    rst_n = 1;
    wait_done("after_reset");
    req = 0;
    check("rst_gnt", last_gnt, 2'b10);
    check("rst_writes", last_wr, 32);
    req = 2'b01;
    wait_k(5);
    req = 0;
    wait_done("drop_req");
    check("drop_writes", last_wr, 32);
    d0 = n_done;
    for (int i = 0; i < 4000; i++) begin
      src_valid = 2'($urandom);
      sink_full = $urandom_range(0, 4) == 0;
      req = 2'($urandom);
      rst_n = $urandom_range(0, 999) != 0;
      cyc();
    end
    check("random_frames_seen", n_done > d0 + 10, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
